icache_responder: RTL and testbench

- Direct-mapped instruction cache that answers the fetch unit's request/response pair: IC_addr/IC_addr_sgn in, IC_ins/IC_ins_sgn out.
- On a miss it refills a whole line from the memory controller as sequential word beats, then delivers the requested word.
- Sits between the instruction fetcher and the memory controller.
- Honours the global rdy pause and the pipeline rollback.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_line_ram.sv | 54 +++++
 rtl/icache_responder.sv | 209 ++++++++++++++++++++
 tb/tb_icache_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the icache_responder slice: default geometry,
// derived address-field widths and the refill state encoding.
package icache_pkg;

  localparam int LINES_DEF          = 16;
  localparam int WORDS_PER_LINE_DEF = 4;

  // Address split for the default geometry: | tag | index | offset | 2'b00 |
  localparam int OFFSET_W   = $clog2(WORDS_PER_LINE_DEF);
  localparam int INDEX_W    = $clog2(LINES_DEF);
  localparam int TAG_W      = 32 - INDEX_W - OFFSET_W - 2;
  localparam int LINE_BYTES = WORDS_PER_LINE_DEF * 4;

  // IDLE answers lookups; REFILL streams one line in from memory.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

endpackage

// File: rtl/icache_line_ram.sv
// Storage for the direct-mapped cache: per-line valid bit, tag and words.
// Reads are combinational on the indexed line; writes are one word per
// clock, and the tag/valid pair is installed together with the last word.
// Only the valid bits are reset; tags and data are don't-care until valid.
module icache_line_ram #(
  parameter int LINES    = 16,
  parameter int WPL      = 4,
  parameter int IDX_W    = 4,
  parameter int OFF_W    = 2,
  parameter int TAG_BITS = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    rd_index_i,
  input  logic [OFF_W-1:0]    rd_offset_i,
  output logic                rd_valid_o,
  output logic [TAG_BITS-1:0] rd_tag_o,
  output logic [31:0]         rd_word_o,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_index_i,
  input  logic [OFF_W-1:0]    wr_offset_i,
  input  logic [31:0]         wr_data_i,
  input  logic                tag_set_i,
  input  logic [TAG_BITS-1:0] wr_tag_i
);

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES][WPL];

  // Valid bits: cleared asynchronously, set when a refill installs its tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (tag_set_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data arrays: plain write ports, no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_index_i][wr_offset_i] <= wr_data_i;
    end
    if (tag_set_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_word_o  = data_q[rd_index_i][rd_offset_i];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache between the fetcher and the memory
// controller. Hits answer one cycle after the lookup; misses stream a whole
// line in and then answer with the requested word.
// Optional: define ICACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt.
//
// Handshakes: IC_addr_sgn is a level request sampled only in IDLE when no
// response is outstanding; IC_ins_sgn is a one-active-cycle pulse and the
// fetcher consumes on that edge. mc_req stays high with a stable mc_addr for
// the whole refill; every mc_valid edge (with rdy=1) transfers one beat, in
// ascending word order. rdy=0 freezes everything; rollback beats the FSM.
module icache_responder
  import icache_pkg::*;
#(
  parameter int LINES          = LINES_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] IC_addr,
  input  logic        IC_addr_sgn,
  output logic [31:0] IC_ins,
  output logic        IC_ins_sgn,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_valid,
  input  logic [31:0] mc_data,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  output state_e      dbg_state_o
);

  localparam int OFF_W    = $clog2(WORDS_PER_LINE);
  localparam int IDX_W    = $clog2(LINES);
  localparam int TAG_BITS = 32 - IDX_W - OFF_W - 2;

  // Request address fields; the byte-lane bits carry no information.
  logic [OFF_W-1:0]    req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_BITS-1:0] req_tag;
  logic                unused_addr_lsb;
  assign req_off         = IC_addr[OFF_W+1:2];
  assign req_idx         = IC_addr[OFF_W+2 +: IDX_W];
  assign req_tag         = IC_addr[31 -: TAG_BITS];
  assign unused_addr_lsb = ^IC_addr[1:0];

  state_e              state_q, state_d;
  logic [31:0]         ins_q, ins_d;
  logic                ins_sgn_q, ins_sgn_d;
  logic                mc_req_q, mc_req_d;
  logic [31:0]         mc_addr_q, mc_addr_d;
  logic [OFF_W-1:0]    beat_q, beat_d;
  logic                cancel_q, cancel_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;

  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [31:0]         rd_word;
  logic [IDX_W-1:0]    rd_index;
  logic [OFF_W-1:0]    rd_offset;
  logic                wr_en, tag_set;
  logic                lookup, hit;

  // In IDLE the array is addressed by the live request, in REFILL by the
  // latched miss address so the requested word can be returned at the end.
  assign rd_index  = (state_q == ST_IDLE) ? req_idx : idx_q;
  assign rd_offset = (state_q == ST_IDLE) ? req_off : off_q;
  assign lookup    = (state_q == ST_IDLE) && IC_addr_sgn && !ins_sgn_q && !rollback;
  assign hit       = rd_valid && (rd_tag == req_tag);

  icache_line_ram #(
    .LINES    (LINES),
    .WPL      (WORDS_PER_LINE),
    .IDX_W    (IDX_W),
    .OFF_W    (OFF_W),
    .TAG_BITS (TAG_BITS)
  ) u_ram (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_index_i  (rd_index),
    .rd_offset_i (rd_offset),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_word_o   (rd_word),
    .wr_en_i     (wr_en),
    .wr_index_i  (idx_q),
    .wr_offset_i (beat_q),
    .wr_data_i   (mc_data),
    .tag_set_i   (tag_set),
    .wr_tag_i    (tag_q)
  );

  // Next-state and output decode: lookup in IDLE, beat collection in REFILL.
  always_comb begin
    state_d   = state_q;
    ins_d     = ins_q;
    ins_sgn_d = ins_sgn_q;
    mc_req_d  = mc_req_q;
    mc_addr_d = mc_addr_q;
    beat_d    = beat_q;
    cancel_d  = cancel_q;
    off_d     = off_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    wr_en     = 1'b0;
    tag_set   = 1'b0;
    if (rdy) begin
      unique case (state_q)
        ST_IDLE: begin
          ins_sgn_d = 1'b0;
          if (lookup) begin
            if (hit) begin
              ins_sgn_d = 1'b1;
              ins_d     = rd_word;
            end else begin
              off_d     = req_off;
              idx_d     = req_idx;
              tag_d     = req_tag;
              mc_addr_d = {IC_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
              mc_req_d  = 1'b1;
              beat_d    = '0;
              state_d   = ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (rollback) begin
            cancel_d = 1'b1;
          end
          if (mc_valid) begin
            wr_en  = 1'b1;
            beat_d = beat_q + OFF_W'(1);
            if (beat_q == OFF_W'(WORDS_PER_LINE - 1)) begin
              tag_set   = 1'b1;
              mc_req_d  = 1'b0;
              // The last word is still on the bus, not yet in the array.
              ins_d     = (off_q == OFF_W'(WORDS_PER_LINE - 1)) ? mc_data : rd_word;
              ins_sgn_d = !(cancel_q || rollback);
              cancel_d  = 1'b0;
              state_d   = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and output registers; everything holds while rdy is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ins_q     <= '0;
      ins_sgn_q <= 1'b0;
      mc_req_q  <= 1'b0;
      mc_addr_q <= '0;
      beat_q    <= '0;
      cancel_q  <= 1'b0;
      off_q     <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      ins_q     <= ins_d;
      ins_sgn_q <= ins_sgn_d;
      mc_req_q  <= mc_req_d;
      mc_addr_q <= mc_addr_d;
      beat_q    <= beat_d;
      cancel_q  <= cancel_d;
      off_q     <= off_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating lookup counters, updated only on active lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy && lookup) begin
      if (hit && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (!hit && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  assign IC_ins      = ins_q;
  assign IC_ins_sgn  = ins_sgn_q;
  assign mc_req      = mc_req_q;
  assign mc_addr     = mc_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed fetch sequence, then randomized
// fetches with random rdy pauses, rollbacks and a mid-refill async reset.
// The reference is a tag/valid table indexed by line number plus a
// memory-content function; a monitor pops expected words on each response.
// Honours ICACHE_PERF_CNT_EN when the DUT is built with it.
module tb_icache_responder;
  import icache_pkg::*;

  localparam int LINES = LINES_DEF;
  localparam int WPL   = WORDS_PER_LINE_DEF;

  localparam int MODE_NORMAL    = 0;
  localparam int MODE_RB_IDLE   = 1;
  localparam int MODE_RB_REFILL = 2;
  localparam int MODE_RST       = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic [31:0] IC_addr = '0;
  logic        IC_addr_sgn = 1'b0;
  logic [31:0] IC_ins;
  logic        IC_ins_sgn;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid = 1'b0;
  logic [31:0] mc_data = '0;
  state_e      dbg_state;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .rollback    (rollback),
    .IC_addr     (IC_addr),
    .IC_addr_sgn (IC_addr_sgn),
    .IC_ins      (IC_ins),
    .IC_ins_sgn  (IC_ins_sgn),
    .mc_req      (mc_req),
    .mc_addr     (mc_addr),
    .mc_valid    (mc_valid),
    .mc_data     (mc_data),
`ifdef ICACHE_PERF_CNT_EN
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
`endif
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state / reference model ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  bit          ref_valid [LINES];
  int unsigned ref_tag   [LINES];
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;
  bit          last_active = 1'b0;
  int          env_beats = 0;
  bit          beat_flag = 1'b0;
  int          rdy_low_pct = 0;
  logic [66:0] snap = '0;
  logic [66:0] cur;
  bit          snap_ok = 1'b0;

  // Backing memory: line 0x10 holds 0xA0..0xA3, everything else is hashed.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    if ((a >> 4) == 32'h1) return 32'hA0 + (w & 32'h3);
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // An edge is "active" when rdy was high at it.
  always @(posedge clk) last_active <= rdy;

  // ---------------- environment: rdy, memory controller, freeze check ----------------
  always @(negedge clk) begin
    if (mc_valid && beat_flag) env_beats++;
    if (!mc_req) env_beats = 0;
    cur = {IC_ins_sgn, IC_ins, mc_req, mc_addr, dbg_state};
    if (rst_n && snap_ok && !last_active) begin
      n_cmp++;
      if (cur !== snap) begin
        n_fail++;
        $display("FAIL frozen_outputs: got 0x%017h expected 0x%017h at %0t", cur, snap, $time);
      end
    end
    snap    = cur;
    snap_ok = rst_n;
    rdy       = ($urandom_range(0, 99) >= rdy_low_pct);
    mc_valid  = 1'b0;
    beat_flag = 1'b0;
    if (rdy && mc_req && env_beats < WPL && $urandom_range(0, 3) != 0) begin
      mc_valid  = 1'b1;
      beat_flag = 1'b1;
      mc_data   = mem_word(mc_addr + 32'(4 * env_beats));
    end else if (rdy && !mc_req && $urandom_range(0, 7) == 0) begin
      mc_valid = 1'b1;
      mc_data  = $urandom;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && IC_ins_sgn && last_active) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_response: got 0x%08h expected none at %0t", IC_ins, $time);
      end else begin
        check("response", IC_ins, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_active();
    int c;
    c = 0;
    do begin
      @(negedge clk); #1;
      c++;
    end while (!last_active && c < 100);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_mc_req", mc_req, 32'd0);
    check("rst_ins_sgn", IC_ins_sgn, 32'd0);
    check("rst_mc_addr", mc_addr, 32'd0);
    check("rst_state", dbg_state, ST_IDLE);
`ifdef ICACHE_PERF_CNT_EN
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    exp_q.delete();
    exp_hits   = 0;
    exp_misses = 0;
    rollback    = 1'b0;
    IC_addr_sgn = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] addr, input int mode);
    int unsigned line, idx, tag;
    bit exp_hit, got_miss, resolved, rb_done;
    int edges;
    line = addr / LINE_BYTES;
    idx  = line % LINES;
    tag  = line / LINES;
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
    if (exp_hit) exp_hits++; else exp_misses++;
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = tag;
    if (exp_hit || mode != MODE_RB_REFILL) exp_q.push_back(mem_word(addr));

    IC_addr     = addr;
    IC_addr_sgn = 1'b1;
    rollback    = (mode == MODE_RB_IDLE);
    edges = 0; resolved = 1'b0; got_miss = 1'b0;
    for (int c = 0; c < 100 && !resolved; c++) begin
      @(negedge clk); #1;
      if (last_active) begin
        edges++;
        rollback = 1'b0;
      end
      if (IC_ins_sgn && last_active) begin
        resolved = 1'b1;
      end else if (mc_req) begin
        resolved = 1'b1;
        got_miss = 1'b1;
      end
    end
    IC_addr_sgn = 1'b0;
    IC_addr     = $urandom;
    if (!resolved) begin
      timeout_fail("lookup");
      return;
    end
    check("hit_or_miss", got_miss, !exp_hit);
    check("lookup_latency", edges, (mode == MODE_RB_IDLE) ? 2 : 1);
    if (got_miss) begin
      check("refill_base", mc_addr, addr & ~32'(LINE_BYTES - 1));
      rb_done = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (!mc_req) break;
        if (mode == MODE_RST && env_beats >= 2) begin
          reset_pulse();
          return;
        end
        if (mode == MODE_RB_REFILL && !rb_done && env_beats >= 2) rollback = 1'b1;
        @(negedge clk); #1;
        if (rollback && last_active) begin
          rollback = 1'b0;
          rb_done  = 1'b1;
        end
      end
      if (mc_req) timeout_fail("refill");
    end
    wait_active();
  endtask

  task automatic directed_seq();
    fetch(32'h0000_0010, MODE_NORMAL);
    fetch(32'h0000_0014, MODE_NORMAL);
    fetch(32'h0000_0018, MODE_NORMAL);
    fetch(32'h0000_0110, MODE_NORMAL);
    fetch(32'h0000_0010, MODE_NORMAL);
    fetch(32'h0000_0110, MODE_NORMAL);
    fetch(32'h0000_001C, MODE_NORMAL);
    fetch(32'h0000_0040, MODE_RB_REFILL);
    fetch(32'h0000_0044, MODE_NORMAL);
    fetch(32'h0000_0048, MODE_RB_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    int r, md;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ins", IC_ins, 32'd0);
    check("reset_ins_sgn", IC_ins_sgn, 32'd0);
    check("reset_mc_req", mc_req, 32'd0);
    check("reset_mc_addr", mc_addr, 32'd0);
    check("reset_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    wait_active();

    rdy_low_pct = 0;
    directed_seq();

    rdy_low_pct = 35;
    reset_pulse();
    wait_active();
    directed_seq();

    for (int n = 0; n < 150; n++) begin
      a = 32'(($urandom_range(0, 2) * LINES + $urandom_range(0, 3)) * LINE_BYTES
              + $urandom_range(0, WPL - 1) * 4 + $urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      md = (r == 0) ? MODE_RB_IDLE : (r == 1) ? MODE_RB_REFILL : MODE_NORMAL;
      fetch(a, md);
    end

    rdy_low_pct = 0;
    wait_active();
    fetch(32'h0000_0080, MODE_RST);
    wait_active();
    fetch(32'h0000_0080, MODE_NORMAL);
    fetch(32'h0000_0084, MODE_NORMAL);

    repeat (5) @(negedge clk);
    #1;
    check("pending_responses", exp_q.size(), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, exp_hits);
    check("miss_cnt", miss_cnt, exp_misses);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #600000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
